// File: rtl/pc_pkg.sv
// Shared types and defaults for the fetch PC generator.
package pc_pkg;

  typedef enum logic [0:0] {RUN, FAULT} state_e;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'hbfc00000;
  localparam int unsigned DEFAULT_INC      = 4;
  localparam int unsigned MAX_SRC          = 32;

  // Callers truncate the result to their channel count.
  function automatic logic [MAX_SRC-1:0] onehot(input int unsigned idx);
    logic [MAX_SRC-1:0] one;
    one = {{(MAX_SRC-1){1'b0}}, 1'b1};
    return one << idx;
  endfunction

endpackage

// File: rtl/pc_prio_sel.sv
// Fixed-priority selector over N_SRC request channels; index 0 wins.
module pc_prio_sel
  import pc_pkg::*;
#(
  parameter int unsigned N_SRC = 4,
  parameter int unsigned WIDTH = 32,
  localparam int unsigned IDXW = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
  input  logic [N_SRC-1:0]       valid,
  input  logic [N_SRC*WIDTH-1:0] targets,
  output logic                   any,
  output logic [IDXW-1:0]        idx,
  output logic [N_SRC-1:0]       sel_oh,
  output logic [WIDTH-1:0]       target
);

  always_comb begin
    idx    = '0;
    target = '0;
    // Walk from lowest priority upward so the lowest index overwrites last.
    for (int i = int'(N_SRC) - 1; i >= 0; i--) begin
      if (valid[i]) begin
        idx    = IDXW'(i);
        target = targets[i*WIDTH +: WIDTH];
      end
    end
    any    = |valid;
    sel_oh = any ? N_SRC'(onehot(32'(idx))) : '0;
  end

endmodule

// File: rtl/pc_gen.sv
// Fetch PC generator: sequential advance, prioritised redirects with stall capture,
// and a fault state for misaligned fetch addresses.
module pc_gen
  import pc_pkg::*;
#(
  parameter int unsigned       WIDTH      = 32,
  parameter int unsigned       N_SRC      = 4,
  parameter logic [WIDTH-1:0]  RESET_PC   = WIDTH'(DEFAULT_RESET_PC),
  parameter int unsigned       INC        = DEFAULT_INC,
  parameter int unsigned       ALIGN_BITS = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_SRC-1:0]       redir_valid,
  input  logic [N_SRC*WIDTH-1:0] redir_pc,
  input  logic                   pc_ready,
  output logic [WIDTH-1:0]       pc,
  output logic                   pc_valid,
  output logic                   pc_adel,
  output logic                   pend_valid,
  output logic [N_SRC-1:0]       redir_src
);

  localparam int unsigned IDXW = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic             pend_valid_q, pend_valid_d;
  logic [IDXW-1:0]  pend_idx_q, pend_idx_d;
  logic [WIDTH-1:0] pend_pc_q, pend_pc_d;
  logic [N_SRC-1:0] redir_src_q, redir_src_d;

  logic             live_any;
  logic [IDXW-1:0]  live_idx;
  logic [N_SRC-1:0] live_oh;
  logic [WIDTH-1:0] live_target;

  logic             live_wins;
  logic             take_redir;
  logic [IDXW-1:0]  sel_idx;
  logic [WIDTH-1:0] sel_pc;

  pc_prio_sel #(
    .N_SRC (N_SRC),
    .WIDTH (WIDTH)
  ) u_live_sel (
    .valid   (redir_valid),
    .targets (redir_pc),
    .any     (live_any),
    .idx     (live_idx),
    .sel_oh  (live_oh),
    .target  (live_target)
  );

  // A live request beats the pending one on equal index so the newest target sticks.
  assign live_wins  = live_any && (!pend_valid_q || (live_idx <= pend_idx_q));
  assign take_redir = live_wins || pend_valid_q;
  assign sel_idx    = live_wins ? live_idx    : pend_idx_q;
  assign sel_pc     = live_wins ? live_target : pend_pc_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= RUN;
      pc_q         <= RESET_PC;
      pend_valid_q <= 1'b0;
      pend_idx_q   <= '0;
      pend_pc_q    <= '0;
      redir_src_q  <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      pend_valid_q <= pend_valid_d;
      pend_idx_q   <= pend_idx_d;
      pend_pc_q    <= pend_pc_d;
      redir_src_q  <= redir_src_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    pend_valid_d = pend_valid_q;
    pend_idx_d   = pend_idx_q;
    pend_pc_d    = pend_pc_q;
    redir_src_d  = redir_src_q;

    unique case (state_q)
      RUN: begin
        if (pc_ready && !pc_adel) begin
          pend_valid_d = 1'b0;
          if (take_redir) begin
            pc_d        = sel_pc;
            redir_src_d = N_SRC'(onehot(32'(sel_idx)));
          end else begin
            pc_d        = pc_q + WIDTH'(INC);
            redir_src_d = '0;
          end
        end else begin
          // Stall, or a misaligned fetch accepted into FAULT: keep redirects pending.
          if (pc_ready) state_d = FAULT;
          if (live_wins) begin
            pend_valid_d = 1'b1;
            pend_idx_d   = live_idx;
            pend_pc_d    = live_target;
          end
        end
      end
      FAULT: begin
        if (take_redir) begin
          state_d      = RUN;
          pc_d         = sel_pc;
          pend_valid_d = 1'b0;
          redir_src_d  = N_SRC'(onehot(32'(sel_idx)));
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    pc         = pc_q;
    pc_valid   = (state_q == RUN);
    pc_adel    = pc_valid && (pc_q[ALIGN_BITS-1:0] != '0);
    pend_valid = pend_valid_q;
    redir_src  = redir_src_q;
  end

endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
- Parametrised next-generation fetch PC generator for the MIPS front end.
- Holds the current fetch PC and presents it to IF under a valid/ready handshake.
- Selects among N prioritised redirect channels (e.g. eret, exception, mispredict, jump), latches redirects that arrive while fetch is stalled instead of dropping them, and flags misaligned fetch addresses with a fault state.

Parameters:
- WIDTH, 32, address width.
- N_SRC, 4, number of redirect channels; index 0 has highest priority.
- RESET_PC, 32'hbfc00000, PC loaded on reset.
- INC, 4, sequential increment in bytes.
- ALIGN_BITS, 2, low PC bits that must be zero.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- redir_valid  in  N_SRC  per-channel redirect request
- redir_pc  in  N_SRC*WIDTH  per-channel target; channel i occupies bits [i*WIDTH +: WIDTH]
- pc_ready  in  1  IF accepts the current pc this cycle
- pc  out  WIDTH  current fetch address
- pc_valid  out  1  pc is a fetch request
- pc_adel  out  1  pc is misaligned (address-error-on-load flag for IF)
- pend_valid  out  1  a captured redirect is waiting
- redir_src  out  N_SRC  one-hot channel applied on the last pc update; 0 if the update was sequential

Behaviour:
- Reset: rst is asynchronous and active-high; clock is clk. Reset forces:
  - pc=RESET_PC, state=RUN, pc_valid=1, pend_valid=0, pending target=0, redir_src=0.
  - pc_adel is derived from pc, so it is 0 for an aligned RESET_PC.
- Reset asserted mid-operation discards any pending redirect and FAULT state immediately.
- Live select:
  - Lowest-index asserted redir_valid wins.
  - live_any = |redir_valid.
- Pending register: {pend_valid, pend_idx, pend_pc}.
- States are RUN and FAULT.
- RUN, pc_ready=1 (handshake, or a stall release):
  - Next pc is chosen in this order:
    - (a) the live redirect, if live_any and (no pending, or live idx <= pend_idx);
    - (b) else the pending redirect;
    - (c) else pc+INC, wrapping modulo 2^WIDTH.
  - pend_valid clears on this update.
  - redir_src is set to the one-hot of the applied channel, or 0 for a sequential update.
  - If the accepted pc had pc_adel=1, go to FAULT instead: pc holds, pc_valid=0.
- RUN, pc_ready=0:
  - pc and pc_valid hold stable.
  - A live redirect is captured if !pend_valid or live idx <= pend_idx. On equal index, the newer target replaces the older one.
  - Lower-priority live redirects are dropped.
- FAULT:
  - pc_valid=0; pc_ready is ignored.
  - Any live redirect (or an existing pending one, using the same priority rule) loads pc, sets pc_valid=1 and returns to RUN next cycle.
  - Without a redirect, FAULT persists.
- pc_adel = pc_valid & (pc[ALIGN_BITS-1:0] != 0). It is combinational from registered state.
- Latency: a redirect applied with pc_ready=1 appears on pc in the next cycle. A captured redirect appears the cycle after the first pc_ready=1.
- Simultaneous live redirect and pending redirect at stall release: the priority rule above applies; the losing request is discarded.
- No combinational path from redir_* to pc.

Decomposition:
- Package pc_pkg:
  - state_e {RUN, FAULT}
  - default RESET_PC and INC constants
  - function onehot(idx)
- One sub-module, pc_prio_sel:
  - Parametrised N_SRC/WIDTH fixed-priority selector.
  - Outputs any, idx, onehot and target.
  - Used once for the live channels; the pending-vs-live compare stays in pc_gen.

Test Plan:
- Reset then pc_ready=1 for 3 cycles -> pc = bfc00000, bfc00004, bfc00008, bfc0000c; redir_src=0.
- pc_ready=1, redir_valid=4'b1010 with ch1=80000180 and ch3=bfc00100 -> next pc=80000180, redir_src=4'b0010.
- Capture with override:
  - pc_ready=0; ch3 redirect to 00400020 -> pend_valid=1, pc unchanged.
  - Next stalled cycle, ch2 redirect to 00400040 -> pending replaced.
  - Release pc_ready=1 -> pc=00400040, pend_valid=0.
- Priority at release:
  - Stall with ch0 pending (bfc00380).
  - At release, live ch2 (00400000) -> pc=bfc00380, ch2 dropped.
  - Repeat with live ch0 at release -> live ch0 target wins.
- Misalignment fault:
  - ch3 redirect to 00400002 -> pc_adel=1.
  - Handshake -> pc_valid=0 (FAULT) for 5 idle cycles.
  - ch1 redirect to 80000180 -> pc_valid=1 with that pc, pc_adel=0.
- Wrap and reset:
  - Redirect to fffffffc, handshake -> pc=00000000.
  - Assert rst asynchronously mid-stall with pend_valid=1 -> pc=bfc00000, pend_valid=0 in the same cycle.
